// File: rtl/conv_encoder_tb_param.sv
// -----------------------------------------------------------------------------
// conv_encoder_tb_param
//
// Tail-biting convolutional encoder, rate 1/N_OUT, constraint length K
// (LTE default: K=7, generators 133/171/165 octal, rate 1/3).
//
// A block is taken from the upstream meta/data FIFOs and stored in an internal
// buffer. The encoder state is seeded with the last K-1 bits of the block, and
// the block is then encoded one DATA_W-bit word per cycle. Each coded stream is
// written to its own show-ahead output FIFO.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   blk_ready           a complete block is waiting upstream
//   blk_meta            show-ahead meta word, bit0 selects LEN_LARGE
//   blk_meta_rdreq      pops the meta FIFO (one cycle per block)
//   blk_data            show-ahead data word, MSB is the earliest bit
//   blk_empty_data      data FIFO empty
//   blk_data_rdreq      pops the data FIFO
//   q                   head word of each output FIFO, stream i at [i*DATA_W +: DATA_W]
//   q_valid             output FIFO i is non-empty
//   rdreq_subblock      pops output FIFO i (ignored when it is empty)
//   busy                encoder is not idle
//   blk_done            one-cycle pulse after the final word of a block is written
//   tb_err              sticky tail-biting state mismatch flag
//
// Build option: define TB_CHECK_EN to compare the final encoder state with the
// initial state at the end of every block (tail-biting check driving tb_err).
// Without it, tb_err is tied low and no compare logic exists.
// -----------------------------------------------------------------------------
module conv_encoder_tb_param #(
  parameter int                 DATA_W    = 8,
  parameter int                 K         = 7,
  parameter int                 N_OUT     = 3,
  parameter logic [N_OUT*K-1:0] G         = {7'o165, 7'o171, 7'o133},
  parameter int                 LEN_SMALL = 1056,
  parameter int                 LEN_LARGE = 6144,
  parameter int                 OUT_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    blk_ready,
  input  logic [7:0]              blk_meta,
  output logic                    blk_meta_rdreq,
  input  logic [DATA_W-1:0]       blk_data,
  input  logic                    blk_empty_data,
  output logic                    blk_data_rdreq,
  output logic [N_OUT*DATA_W-1:0] q,
  output logic [N_OUT-1:0]        q_valid,
  input  logic [N_OUT-1:0]        rdreq_subblock,
  output logic                    busy,
  output logic                    blk_done,
  output logic                    tb_err
);

  localparam int S_W      = K - 1;
  localparam int NW_MAX   = LEN_LARGE / DATA_W;
  localparam int NW_SMALL = LEN_SMALL / DATA_W;
  localparam int CW       = $clog2(NW_MAX + 1);
  localparam int AW       = (NW_MAX > 1) ? $clog2(NW_MAX) : 1;
  localparam int PW       = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int FW       = $clog2(OUT_DEPTH + 1);
  localparam int ENC_W    = S_W + N_OUT * DATA_W;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_META   = 3'd1,
    ST_LOAD   = 3'd2,
    ST_ENCODE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Encodes one word MSB-first starting from state s_in. Returns
  // {final_state, coded words}; coded bit for input bit b lands on bit b of
  // each stream, so the earliest input bit produces the output MSB.
  function automatic logic [ENC_W-1:0] encode_word(input logic [DATA_W-1:0] w,
                                                   input logic [S_W-1:0]    s_in);
    logic [S_W-1:0]          s;
    logic [K-1:0]            v;
    logic [N_OUT*DATA_W-1:0] c;
    s = s_in;
    v = {K{1'b0}};
    c = {(N_OUT*DATA_W){1'b0}};
    for (int b = DATA_W - 1; b >= 0; b--) begin
      // v[K-1] is the new bit, v[K-2] the newest stored bit, v[0] the oldest
      v[K-1] = w[b];
      for (int j = 0; j < S_W; j++) begin
        v[S_W-1-j] = s[j];
      end
      for (int i = 0; i < N_OUT; i++) begin
        c[i*DATA_W + b] = ^(v & G[i*K +: K]);
      end
      s = {s[S_W-2:0], w[b]};
    end
    return {s, c};
  endfunction

  state_t                  state_r;
  state_t                  next_state_s;
  logic                    busy_r;
  logic                    blk_done_r;
  logic                    meta_rdreq_r;
  logic [CW-1:0]           nwords_r;
  logic [CW-1:0]           load_cnt_r;
  logic [CW-1:0]           rd_addr_r;
  logic [CW-1:0]           out_cnt_r;
  logic [S_W-1:0]          tail_r;
  logic [S_W-1:0]          s_r;
  logic                    rd_vld_r;
  logic [DATA_W-1:0]       rd_data_r;
  logic                    enc_vld_r;
  logic [N_OUT*DATA_W-1:0] enc_word_r;
  logic [DATA_W-1:0]       buf_mem [NW_MAX];

  logic [DATA_W-1:0]       fifo_mem [N_OUT][OUT_DEPTH];
  logic [FW-1:0]           fifo_cnt_r [N_OUT];
  logic [FW-1:0]           fifo_cnt_nxt_s [N_OUT];
  logic [PW-1:0]           fifo_rd_ptr_r [N_OUT];
  logic [PW-1:0]           fifo_wr_ptr_r;
  logic [N_OUT-1:0]        fifo_rd_s;
  logic [N_OUT-1:0]        q_valid_r;

  logic                    pop_s;
  logic                    last_pop_s;
  logic [S_W+DATA_W-1:0]   load_cat_s;
  logic [S_W-1:0]          tail_next_s;
  logic                    fifo_room_s;
  logic                    rd_en_s;
  logic                    wr_s;
  logic                    last_wr_s;
  logic [ENC_W-1:0]        enc_s;
  logic                    meta_unused_s;

  // Only the length-select bit of the meta word is used
  assign meta_unused_s = ^blk_meta[7:1];

  assign pop_s       = (state_r == ST_LOAD) && !blk_empty_data;
  assign last_pop_s  = pop_s && (load_cnt_r == (nwords_r - CW'(1)));
  // Keeps the most recent K-1 bits seen; after the last word this is s_init
  assign load_cat_s  = {tail_r, blk_data};
  assign tail_next_s = load_cat_s[S_W-1:0];
  assign wr_s        = enc_vld_r;
  assign last_wr_s   = wr_s && (out_cnt_r == (nwords_r - CW'(1)));
  assign enc_s       = encode_word(rd_data_r, s_r);
  // At most two words are in flight, so issuing only at <= DEPTH-3 never overflows
  assign rd_en_s     = (state_r == ST_ENCODE) && (rd_addr_r < nwords_r) && fifo_room_s;

  // All output FIFOs must have room for the in-flight words plus one more
  always_comb begin
    fifo_room_s = 1'b1;
    for (int i = 0; i < N_OUT; i++) begin
      if (fifo_cnt_r[i] > FW'(OUT_DEPTH - 3)) begin
        fifo_room_s = 1'b0;
      end else begin
        fifo_room_s = fifo_room_s;
      end
    end
  end

  // Next-state logic for the block sequencer
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (blk_ready) begin
          next_state_s = ST_META;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_META: next_state_s = ST_LOAD;
      ST_LOAD: begin
        if (last_pop_s) begin
          next_state_s = ST_ENCODE;
        end else begin
          next_state_s = ST_LOAD;
        end
      end
      ST_ENCODE: begin
        if (last_wr_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_ENCODE;
        end
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register and registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      busy_r       <= 1'b0;
      blk_done_r   <= 1'b0;
      meta_rdreq_r <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      busy_r       <= (next_state_s != ST_IDLE);
      blk_done_r   <= (next_state_s == ST_DONE);
      meta_rdreq_r <= (next_state_s == ST_META);
    end
  end

  // Block length, load counter and tail capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nwords_r   <= {CW{1'b0}};
      load_cnt_r <= {CW{1'b0}};
      tail_r     <= {S_W{1'b0}};
    end else begin
      if (state_r == ST_META) begin
        nwords_r   <= blk_meta[0] ? CW'(NW_MAX) : CW'(NW_SMALL);
        load_cnt_r <= {CW{1'b0}};
      end
      if (pop_s) begin
        load_cnt_r <= load_cnt_r + CW'(1);
        tail_r     <= tail_next_s;
      end
    end
  end

  // Block buffer write port
  always_ff @(posedge clk) begin
    if (pop_s) begin
      buf_mem[load_cnt_r[AW-1:0]] <= blk_data;
    end
  end

  // Encode pipeline: buffer read, then encode, then FIFO write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_addr_r  <= {CW{1'b0}};
      out_cnt_r  <= {CW{1'b0}};
      rd_vld_r   <= 1'b0;
      rd_data_r  <= {DATA_W{1'b0}};
      enc_vld_r  <= 1'b0;
      enc_word_r <= {(N_OUT*DATA_W){1'b0}};
      s_r        <= {S_W{1'b0}};
    end else begin
      if (state_r == ST_META) begin
        rd_addr_r <= {CW{1'b0}};
        out_cnt_r <= {CW{1'b0}};
      end
      rd_vld_r  <= rd_en_s;
      enc_vld_r <= rd_vld_r;
      if (rd_en_s) begin
        rd_addr_r <= rd_addr_r + CW'(1);
        rd_data_r <= buf_mem[rd_addr_r[AW-1:0]];
      end
      if (rd_vld_r) begin
        enc_word_r <= enc_s[N_OUT*DATA_W-1:0];
        s_r        <= enc_s[ENC_W-1 -: S_W];
      end else if (last_pop_s) begin
        s_r <= tail_next_s;
      end
      if (wr_s) begin
        out_cnt_r <= out_cnt_r + CW'(1);
      end
    end
  end

`ifdef TB_CHECK_EN
  logic [S_W-1:0] s_init_r;
  logic           tb_err_r;

  // Tail-biting check: final state must equal the seeded state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_init_r <= {S_W{1'b0}};
      tb_err_r <= 1'b0;
    end else begin
      if (last_pop_s) begin
        s_init_r <= tail_next_s;
      end
      if (last_wr_s && (s_r != s_init_r)) begin
        tb_err_r <= 1'b1;
      end
    end
  end

  assign tb_err = tb_err_r;
`else
  assign tb_err = 1'b0;
`endif

  // Output FIFO pop qualification and occupancy update
  always_comb begin
    fifo_rd_s = {N_OUT{1'b0}};
    for (int i = 0; i < N_OUT; i++) begin
      fifo_cnt_nxt_s[i] = fifo_cnt_r[i];
    end
    for (int i = 0; i < N_OUT; i++) begin
      fifo_rd_s[i]      = rdreq_subblock[i] && q_valid_r[i];
      fifo_cnt_nxt_s[i] = fifo_cnt_r[i] + FW'(wr_s) - FW'(fifo_rd_s[i]);
    end
  end

  // Output FIFO pointers, occupancy and valid flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_wr_ptr_r <= {PW{1'b0}};
      q_valid_r     <= {N_OUT{1'b0}};
      for (int i = 0; i < N_OUT; i++) begin
        fifo_cnt_r[i]    <= {FW{1'b0}};
        fifo_rd_ptr_r[i] <= {PW{1'b0}};
      end
    end else begin
      if (wr_s) begin
        fifo_wr_ptr_r <= (fifo_wr_ptr_r == PW'(OUT_DEPTH - 1)) ? {PW{1'b0}}
                                                               : fifo_wr_ptr_r + PW'(1);
      end
      for (int i = 0; i < N_OUT; i++) begin
        if (fifo_rd_s[i]) begin
          fifo_rd_ptr_r[i] <= (fifo_rd_ptr_r[i] == PW'(OUT_DEPTH - 1)) ? {PW{1'b0}}
                                                                       : fifo_rd_ptr_r[i] + PW'(1);
        end
        fifo_cnt_r[i] <= fifo_cnt_nxt_s[i];
        q_valid_r[i]  <= (fifo_cnt_nxt_s[i] != {FW{1'b0}});
      end
    end
  end

  // Output FIFO storage; all streams share one write pointer
  always_ff @(posedge clk) begin
    if (wr_s) begin
      for (int i = 0; i < N_OUT; i++) begin
        fifo_mem[i][fifo_wr_ptr_r] <= enc_word_r[i*DATA_W +: DATA_W];
      end
    end
  end

  // Head words; forced to zero while a FIFO is empty so stale data never shows
  always_comb begin
    q = {(N_OUT*DATA_W){1'b0}};
    for (int i = 0; i < N_OUT; i++) begin
      if (q_valid_r[i]) begin
        q[i*DATA_W +: DATA_W] = fifo_mem[i][fifo_rd_ptr_r[i]];
      end else begin
        q[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end
    end
  end

  assign q_valid        = q_valid_r;
  assign busy           = busy_r;
  assign blk_done       = blk_done_r;
  assign blk_meta_rdreq = meta_rdreq_r;
  assign blk_data_rdreq = pop_s;

endmodule
